// File: rtl/fast_field_op_seq_if.sv
// Descriptor-in / field-op-out handshake bundle for fast_field_op_seq.
// master = upstream descriptor source plus downstream op sink; slave = the sequencer.
interface fast_field_op_seq_if #(
  parameter int MAX_FIELDS = 10,
  parameter int TF_W       = 10,
  parameter int PMAP_W     = 64,
  parameter int MSG_ID_W   = 20
);
  localparam int NF_W  = $clog2(MAX_FIELDS + 1);
  localparam int IDX_W = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1;
  localparam int OP_W  = TF_W + MSG_ID_W + 2;

  logic                                 msg_valid;
  logic                                 msg_ready;
  logic [NF_W-1:0]                      msg_num_fields;
  logic [MAX_FIELDS-1:0][TF_W-1:0]      msg_template;
  logic [PMAP_W-1:0]                    msg_pmap;

  logic                                 op_valid;
  logic                                 op_ready;
  logic [OP_W-1:0]                      op_data;
  logic [IDX_W-1:0]                     op_field_idx;
  logic                                 op_last;

  modport master (
    output msg_valid, msg_num_fields, msg_template, msg_pmap, op_ready,
    input  msg_ready, op_valid, op_data, op_field_idx, op_last
  );

  modport slave (
    input  msg_valid, msg_num_fields, msg_template, msg_pmap, op_ready,
    output msg_ready, op_valid, op_data, op_field_idx, op_last
  );
endinterface

// File: rtl/fast_field_op_seq.sv
// FAST field-op sequencer: takes one message descriptor, emits one field op per cycle,
// walking the presence map only for operators that consume a pmap bit.
module fast_field_op_seq #(
  parameter int MAX_FIELDS = 10,
  parameter int TF_W       = 10,
  parameter int OPC_W      = 3,
  parameter int PMAP_W     = 64,
  parameter int MSG_ID_W   = 20
) (
  input  logic                clk,
  input  logic                rst,
  fast_field_op_seq_if.slave  bus,
  output logic [MSG_ID_W-1:0] msg_id,
  output logic                err_pmap_uflow,
  output logic                err_bad_op
);
  localparam int NF_W  = $clog2(MAX_FIELDS + 1);
  localparam int IDX_W = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1;
  localparam int P_W   = $clog2(PMAP_W + MAX_FIELDS + 1);

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_EMIT = 1'b1;

  localparam logic [OPC_W-1:0] OPC_COPY = OPC_W'(2);
  localparam logic [OPC_W-1:0] OPC_DFLT = OPC_W'(3);
  localparam logic [OPC_W-1:0] OPC_DLTA = OPC_W'(4);
  localparam logic [OPC_W-1:0] OPC_INCR = OPC_W'(5);
  localparam logic [OPC_W-1:0] OPC_TAIL = OPC_W'(6);
  localparam logic [OPC_W-1:0] OPC_RSVD = OPC_W'(7);

  logic [0:0]                      state_q;
  logic [MAX_FIELDS-1:0][TF_W-1:0] tmpl_q;
  logic [PMAP_W-1:0]               pmap_q;
  logic [NF_W-1:0]                 n_q;
  logic [IDX_W-1:0]                f_q;
  logic [P_W-1:0]                  p_q;
  logic                            err_uflow_q, err_bad_q;

  logic [NF_W-1:0]   n_in;
  logic [TF_W-1:0]   cur_tmpl;
  logic [OPC_W-1:0]  opc;
  logic [PMAP_W-1:0] pmap_shift;
  logic              emit, consume, p_in_range, pbit, mem_wr, last;
  logic              op_hs, last_hs, accept, zero_accept;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    n_in        = (bus.msg_num_fields > NF_W'(MAX_FIELDS)) ? NF_W'(MAX_FIELDS) : bus.msg_num_fields;
    emit        = (state_q == S_EMIT);
    cur_tmpl    = tmpl_q[f_q];
    opc         = cur_tmpl[TF_W-1 -: OPC_W];
    consume     = (opc == OPC_COPY) || (opc == OPC_DFLT) || (opc == OPC_INCR) || (opc == OPC_TAIL);
    p_in_range  = (p_q < P_W'(PMAP_W));
    pmap_shift  = pmap_q >> p_q;
    pbit        = consume && p_in_range && pmap_shift[0];
    mem_wr      = 1'b0;
    case (opc)
      OPC_COPY, OPC_TAIL: mem_wr = pbit;
      OPC_DLTA, OPC_INCR: mem_wr = 1'b1;
      default:            mem_wr = 1'b0;
    endcase
    last        = emit && (NF_W'(f_q) == n_q - NF_W'(1));
    op_hs       = emit && bus.op_ready;
    last_hs     = op_hs && last;
    // The next descriptor can slip in on the cycle the final op is taken.
    bus.msg_ready = !rst && (!emit || (last && bus.op_ready));
    accept      = bus.msg_valid && bus.msg_ready;
    zero_accept = accept && (n_in == '0);
  end

  assign bus.op_valid     = emit;
  assign bus.op_last      = last;
  assign bus.op_field_idx = emit ? f_q : '0;
  assign bus.op_data      = emit ? {mem_wr, pbit, msg_id, cur_tmpl} : '0;
  assign err_pmap_uflow   = err_uflow_q || (emit && consume && !p_in_range);
  assign err_bad_op       = err_bad_q   || (emit && (opc == OPC_RSVD));

  // NOTE: descriptor storage has no reset; it is only read in EMIT, which reset never leaves it in.
  always_ff @(posedge clk) begin
    if (accept) begin
      tmpl_q <= bus.msg_template;
      pmap_q <= bus.msg_pmap;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      n_q         <= '0;
      f_q         <= '0;
      p_q         <= '0;
      msg_id      <= '0;
      err_uflow_q <= 1'b0;
      err_bad_q   <= 1'b0;
    end else begin
      // A finishing message and an empty descriptor taken in the same cycle each consume an ID.
      msg_id      <= msg_id + MSG_ID_W'(last_hs) + MSG_ID_W'(zero_accept);
      err_uflow_q <= err_pmap_uflow;
      err_bad_q   <= err_bad_op;
      if (accept && (n_in != '0)) begin
        state_q <= S_EMIT;
        n_q     <= n_in;
        f_q     <= '0;
        p_q     <= '0;
      end else if (last_hs) begin
        state_q <= S_IDLE;
      end else if (op_hs) begin
        f_q <= f_q + 1'b1;
        p_q <= p_q + P_W'(consume);
      end
    end
  end
endmodule
